// File: rtl/gpio_stream_tx.sv
// Beat FIFO feeding a GPIO stream: frame-start marker, then one R/G/B data beat
// per strobe with optional idle gap between beats.
module gpio_stream_tx #(
    parameter int DEPTH = 4,
    parameter int GAP   = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         stop,
    input  logic         wr_valid,
    output logic         wr_ready,
    input  logic [1:0]   wr_chan,
    input  logic [127:0] wr_data,
    output logic [127:0] GPIO,
    output logic         GPIOEnR,
    output logic         GPIOEnG,
    output logic         GPIOEnB,
    output logic         GPIOEn,
    output logic         busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int GW = $clog2(GAP + 2);

    typedef enum logic [1:0] {S_IDLE, S_MARK, S_SEND, S_WAIT} state_t;

    state_t         r_state, w_next;
    logic [129:0]   r_mem [DEPTH];
    logic [AW-1:0]  r_wptr, r_rptr;
    logic [AW:0]    r_count;
    logic           r_stop_pend;
    logic [GW-1:0]  r_gap_cnt;
    logic [127:0]   r_gpio, w_gpio;
    logic           r_en, r_enr, r_eng, r_enb;
    logic           w_en, w_enr, w_eng, w_enb;
    logic           w_push, w_pop, w_stop_clr, w_gap_load;
    logic [129:0]   w_head;

    assign wr_ready = (r_count < (AW + 1)'(DEPTH));
    // Reserved channel 3 completes the handshake but never enters the FIFO.
    assign w_push   = wr_valid & wr_ready & (wr_chan != 2'd3);
    assign w_head   = r_mem[r_rptr];

    always_comb begin
        w_next     = r_state;
        w_pop      = 1'b0;
        w_stop_clr = 1'b0;
        w_gap_load = 1'b0;
        w_gpio     = '0;
        w_en       = 1'b0;
        w_enr      = 1'b0;
        w_eng      = 1'b0;
        w_enb      = 1'b0;
        case (r_state)
            S_IDLE: if (start) w_next = S_MARK;
            S_MARK: begin
                w_en   = 1'b1;
                w_next = S_SEND;
            end
            S_SEND: begin
                if (r_count != '0) begin
                    w_pop  = 1'b1;
                    w_gpio = w_head[127:0];
                    case (w_head[129:128])
                        2'd0:    w_enr = 1'b1;
                        2'd1:    w_eng = 1'b1;
                        default: w_enb = 1'b1;
                    endcase
                    if (GAP > 0) begin
                        w_next     = S_WAIT;
                        w_gap_load = 1'b1;
                    end
                end else if (r_stop_pend) begin
                    w_next     = S_IDLE;
                    w_stop_clr = 1'b1;
                end
            end
            S_WAIT: if (r_gap_cnt <= GW'(1)) w_next = S_SEND;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_stop_pend <= 1'b0;
            r_gap_cnt   <= '0;
            r_gpio      <= '0;
            r_en        <= 1'b0;
            r_enr       <= 1'b0;
            r_eng       <= 1'b0;
            r_enb       <= 1'b0;
        end else begin
            r_state <= w_next;
            r_gpio  <= w_gpio;
            r_en    <= w_en;
            r_enr   <= w_enr;
            r_eng   <= w_eng;
            r_enb   <= w_enb;
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW + 1)'(1);
                2'b01:   r_count <= r_count - (AW + 1)'(1);
                default: r_count <= r_count;
            endcase
            if (w_stop_clr)
                r_stop_pend <= 1'b0;
            else if (stop && r_state != S_IDLE)
                r_stop_pend <= 1'b1;
            // Loaded with GAP on entry; WAIT exits as the count reaches zero, giving GAP idle cycles.
            if (w_gap_load)
                r_gap_cnt <= GW'(GAP);
            else if (r_state == S_WAIT && r_gap_cnt != '0)
                r_gap_cnt <= r_gap_cnt - GW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= {wr_chan, wr_data};
    end

    assign GPIO    = r_gpio;
    assign GPIOEn  = r_en;
    assign GPIOEnR = r_enr;
    assign GPIOEnG = r_eng;
    assign GPIOEnB = r_enb;
    assign busy    = (r_state != S_IDLE);

endmodule

// File: tb/tb_gpio_stream_tx.sv
// Bench for gpio_stream_tx: directed vector table, multi-cycle corner sequences,
// and a randomized run scored against an in-order beat queue.
module tb_gpio_stream_tx;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic         start, stop, wv, rdy, er, eg, eb, en, busy;
    logic [1:0]   ch;
    logic [127:0] data, gpio;

    logic         b_start, b_stop, b_wv, b_rdy, b_er, b_eg, b_eb, b_en, b_busy;
    logic [1:0]   b_ch;
    logic [127:0] b_data, b_gpio;

    gpio_stream_tx #(.DEPTH(4), .GAP(0)) u0 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .wr_valid(wv),
        .wr_ready(rdy), .wr_chan(ch), .wr_data(data), .GPIO(gpio),
        .GPIOEnR(er), .GPIOEnG(eg), .GPIOEnB(eb), .GPIOEn(en), .busy(busy)
    );

    gpio_stream_tx #(.DEPTH(4), .GAP(2)) u2 (
        .clk(clk), .rst(rst), .start(b_start), .stop(b_stop), .wr_valid(b_wv),
        .wr_ready(b_rdy), .wr_chan(b_ch), .wr_data(b_data), .GPIO(b_gpio),
        .GPIOEnR(b_er), .GPIOEnG(b_eg), .GPIOEnB(b_eb), .GPIOEn(b_en), .busy(b_busy)
    );

    typedef struct {
        logic         start, stop, wv;
        logic [1:0]   ch;
        logic [127:0] data;
        logic [127:0] gpio;
        logic         en, er, eg, eb, busy, rdy;
    } vec_t;

    typedef struct {
        logic [1:0]   ch;
        logic [127:0] d;
    } beat_t;

    localparam logic [127:0] D  = 128'h00000040_00000030_00000020_00000010;
    localparam logic [127:0] D3 = 128'h00000040_00000030_00000020_00000123;
    localparam logic [127:0] DX = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;

    vec_t  tbl [15];
    beat_t sbq [$];
    int    checks = 0;
    int    errors = 0;
    bit    sb_on  = 1'b0;

    function automatic vec_t mk(logic st, logic sp, logic v, logic [1:0] c, logic [127:0] d,
                                logic [127:0] g, logic e, logic r, logic gg, logic b,
                                logic bz, logic rd);
        vec_t x;
        x.start = st; x.stop = sp; x.wv = v; x.ch = c; x.data = d;
        x.gpio = g; x.en = e; x.er = r; x.eg = gg; x.eb = b; x.busy = bz; x.rdy = rd;
        return x;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic monitor();
        int    ns;
        beat_t b;
        logic [2:0] want;
        ns = int'(en) + int'(er) + int'(eg) + int'(eb);
        chk("sb_one_strobe", 128'(ns <= 1), 128'(1));
        if (er | eg | eb) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: data strobe with model queue empty");
            end else begin
                b = sbq.pop_front();
                want = (b.ch == 2'd0) ? 3'b100 : (b.ch == 2'd1) ? 3'b010 : 3'b001;
                chk("sb_chan", 128'({er, eg, eb}), 128'(want));
                chk("sb_data", gpio, b.d);
            end
        end else begin
            chk("sb_gpio_zero", gpio, '0);
        end
        if (wv && rdy && ch != 2'd3) sbq.push_back('{ch: ch, d: data});
    endtask

    task automatic tick();
        @(negedge clk);
        if (sb_on) monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string nm);
        for (int i = 0; i < 20 && busy; i++) tick();
        chk(nm, 128'(busy), 128'(0));
    endtask

    task automatic push0(input logic [1:0] c, input logic [127:0] d);
        wv = 1'b1; ch = c; data = d;
        tick();
        wv = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int          t[$];
        logic [2:0]  o[$];
        int          n, last, fall;
        bit          hit;

        rst = 1'b0;
        start = 0; stop = 0; wv = 0; ch = 0; data = '0;
        b_start = 0; b_stop = 0; b_wv = 0; b_ch = 0; b_data = '0;

        tbl[0]  = mk(0, 1, 1, 2'd0, D,  '0, 0, 0, 0, 0, 0, 1);
        tbl[1]  = mk(0, 0, 1, 2'd1, D,  '0, 0, 0, 0, 0, 0, 1);
        tbl[2]  = mk(0, 0, 1, 2'd3, DX, '0, 0, 0, 0, 0, 0, 1);
        tbl[3]  = mk(0, 0, 1, 2'd2, D,  '0, 0, 0, 0, 0, 0, 1);
        tbl[4]  = mk(0, 0, 1, 2'd0, D3, '0, 0, 0, 0, 0, 0, 1);
        tbl[5]  = mk(1, 0, 0, 2'd0, '0, '0, 0, 0, 0, 0, 0, 0);
        tbl[6]  = mk(0, 0, 1, 2'd1, DX, '0, 0, 0, 0, 0, 1, 0);
        tbl[7]  = mk(0, 0, 0, 2'd0, '0, '0, 1, 0, 0, 0, 1, 0);
        tbl[8]  = mk(1, 0, 0, 2'd0, '0, D,  0, 1, 0, 0, 1, 1);
        tbl[9]  = mk(0, 0, 0, 2'd0, '0, D,  0, 0, 1, 0, 1, 1);
        tbl[10] = mk(0, 0, 0, 2'd0, '0, D,  0, 0, 0, 1, 1, 1);
        tbl[11] = mk(0, 0, 0, 2'd0, '0, D3, 0, 1, 0, 0, 1, 1);
        tbl[12] = mk(0, 1, 0, 2'd0, '0, '0, 0, 0, 0, 0, 1, 1);
        tbl[13] = mk(0, 0, 0, 2'd0, '0, '0, 0, 0, 0, 0, 1, 1);
        tbl[14] = mk(0, 0, 0, 2'd0, '0, '0, 0, 0, 0, 0, 0, 1);

        // Reset state
        #3;
        chk("rst_gpio", gpio, '0);
        chk("rst_strobes", 128'({en, er, eg, eb}), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_ready", 128'(rdy), 128'(1));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Vector table: IDLE fill to full, start, R G B R(0x123), stop ignored in IDLE
        for (int i = 0; i < 15; i++) begin
            start = tbl[i].start; stop = tbl[i].stop; wv = tbl[i].wv;
            ch = tbl[i].ch; data = tbl[i].data;
            @(negedge clk);
            chk($sformatf("tbl%0d_gpio", i), gpio, tbl[i].gpio);
            chk($sformatf("tbl%0d_strobes", i), 128'({en, er, eg, eb}),
                128'({tbl[i].en, tbl[i].er, tbl[i].eg, tbl[i].eb}));
            chk($sformatf("tbl%0d_busy", i), 128'(busy), 128'(tbl[i].busy));
            chk($sformatf("tbl%0d_ready", i), 128'(rdy), 128'(tbl[i].rdy));
            @(posedge clk);
            #1;
        end
        start = 0; stop = 0; wv = 0;

        // GAP=2: data strobes 3 cycles apart
        for (int i = 0; i < 3; i++) begin
            b_wv = 1'b1; b_ch = 2'(i); b_data = D;
            tick();
        end
        b_wv = 1'b0; b_start = 1'b1;
        tick();
        b_start = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (b_er | b_eg | b_eb) begin
                t.push_back(c);
                o.push_back({b_er, b_eg, b_eb});
                chk("gap_data", b_gpio, D);
            end
            @(posedge clk);
            #1;
        end
        chk("gap_count", 128'(t.size()), 128'(3));
        if (t.size() == 3) begin
            chk("gap_space1", 128'(t[1] - t[0]), 128'(3));
            chk("gap_space2", 128'(t[2] - t[1]), 128'(3));
            chk("gap_order", 128'({o[0], o[1], o[2]}), 128'(9'b100_010_001));
        end
        b_stop = 1'b1;
        tick();
        b_stop = 1'b0;
        for (int i = 0; i < 20 && b_busy; i++) tick();
        chk("gap_idle", 128'(b_busy), 128'(0));

        // Reserved channel between two G beats
        push0(2'd1, D); push0(2'd3, DX); push0(2'd1, D3);
        start = 1'b1;
        tick();
        start = 1'b0;
        t.delete();
        n = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (eg) t.push_back(c);
            if (er | eb) n++;
            @(posedge clk);
            #1;
        end
        chk("ch3_eng_count", 128'(t.size()), 128'(2));
        chk("ch3_other", 128'(n), 128'(0));
        if (t.size() == 2) chk("ch3_adjacent", 128'(t[1] - t[0]), 128'(1));
        stop = 1'b1;
        tick();
        stop = 1'b0;
        wait_idle("ch3_idle");

        // Stop with two beats queued: both leave, busy falls the cycle after the last
        push0(2'd0, D); push0(2'd2, D3);
        start = 1'b1;
        tick();
        start = 1'b0; stop = 1'b1;
        tick();
        stop = 1'b0;
        n = 0; last = -1; fall = -1;
        for (int c = 0; c < 15 && fall < 0; c++) begin
            @(negedge clk);
            if (er | eg | eb) begin n++; last = c; end
            if (!busy) fall = c;
            @(posedge clk);
            #1;
        end
        chk("stop_beats", 128'(n), 128'(2));
        chk("stop_fall", 128'(fall - last), 128'(1));

        // Reset mid-frame
        push0(2'd0, D); push0(2'd1, D); push0(2'd2, D);
        start = 1'b1;
        tick();
        start = 1'b0;
        hit = 1'b0;
        for (int c = 0; c < 10 && !hit; c++) begin
            @(negedge clk);
            if (er) hit = 1'b1;
            else begin @(posedge clk); #1; end
        end
        chk("mid_reached", 128'(hit), 128'(1));
        rst = 1'b0;
        #1;
        chk("mid_gpio", gpio, '0);
        chk("mid_strobes", 128'({en, er, eg, eb}), 128'(0));
        chk("mid_busy", 128'(busy), 128'(0));
        chk("mid_ready", 128'(rdy), 128'(1));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        n = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (en | er | eg | eb | busy) n++;
            @(posedge clk);
            #1;
        end
        chk("post_rst_quiet", 128'(n), 128'(0));
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0; last = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (en) last++;
            if (er | eg | eb) n++;
            @(posedge clk);
            #1;
        end
        chk("post_rst_mark", 128'(last), 128'(1));
        chk("post_rst_flushed", 128'(n), 128'(0));
        stop = 1'b1;
        tick();
        stop = 1'b0;
        wait_idle("post_rst_idle");

        // Randomized traffic against the in-order beat queue
        sbq.delete();
        sb_on = 1'b1;
        for (int i = 0; i < 800; i++) begin
            start = ($urandom % 8) == 0;
            stop  = ($urandom % 24) == 0;
            wv    = ($urandom % 2) == 0;
            ch    = 2'($urandom % 4);
            data  = {$urandom, $urandom, $urandom, $urandom};
            tick();
        end
        wv = 1'b0;
        for (int i = 0; i < 300 && !(sbq.size() == 0 && !busy); i++) begin
            start = !busy && sbq.size() != 0;
            stop  = 1'b1;
            tick();
        end
        start = 1'b0; stop = 1'b0;
        tick();
        sb_on = 1'b0;
        chk("rand_drained", 128'(sbq.size()), 128'(0));
        chk("rand_idle", 128'(busy), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
